// File: rtl/stim_gen_pkg.sv
// stim_gen_pkg: shared types and constants for the stimulus generator.
//   stim_mode_e  : stimulus mode selected at burst start
//   stim_state_e : burst FSM states
//   LFSR_TAPS    : Galois feedback mask for the 16-bit right-shift LFSR
//   lfsr_next()  : one LFSR step
package stim_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RAND   = 2'd0,
        MODE_INC    = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_CORNER = 2'd3
    } stim_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stim_state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/stim_lfsr.sv
// stim_lfsr: 16-bit Galois right-shift LFSR used for the random stimulus mode.
// Only rst returns it to SEED, so the sequence continues across bursts.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   step_en in   advance one step on this clock edge
//   state   out  current LFSR contents
module stim_lfsr
    import stim_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    output logic [15:0] state
);

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= SEED;
        end else if (step_en) begin
            lfsr_reg <= lfsr_next(lfsr_reg);
        end
    end

    assign state = lfsr_reg;

endmodule

// File: rtl/stim_gen.sv
// stim_gen: programmable-length burst generator of operand pairs over a
// valid/ready handshake. Modes: random (LFSR), incrementing, walking-one and
// corner values.
// Optional feature: define STIM_GEN_CORNER_EN to build the corner sequence
// for mode 3; without it mode 3 behaves exactly like the random mode.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start_in  in   start a burst (sampled in IDLE only)
//   mode_in   in   stimulus mode, latched at start
//   count_in  in   beats in the burst, latched at start
//   ready_in  in   downstream accepts the current beat
//   valid_ou  out  a_ou/b_ou hold a valid beat
//   a_ou      out  operand A
//   b_ou      out  operand B
//   busy_ou   out  high in RUN and DONE
//   done_ou   out  one-cycle pulse when the burst completes
//   sent_ou   out  beats accepted in the current or last burst
module stim_gen
    import stim_gen_pkg::*;
#(
    parameter int          DATA_W = 5,
    parameter int          CNT_W  = 8,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [1:0]        mode_in,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              ready_in,
    output logic              valid_ou,
    output logic [DATA_W-1:0] a_ou,
    output logic [DATA_W-1:0] b_ou,
    output logic              busy_ou,
    output logic              done_ou,
    output logic [CNT_W-1:0]  sent_ou
);

    localparam int K_W = $clog2(DATA_W);
    localparam logic [K_W-1:0] K_MAX = K_W'(DATA_W - 1);

    stim_state_e        state_reg;
    stim_mode_e         mode_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   sent_reg;   // doubles as the beat index idx
    logic [K_W-1:0]     k_reg;
    logic               valid_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               accept;
    logic               use_lfsr;
    logic [CNT_W-1:0]   sent_inc;
    logic [15:0]        lfsr_state;
    logic [DATA_W-1:0]  a_mux;
    logic [DATA_W-1:0]  b_mux;
    logic               unused_lfsr_bits;

    assign accept   = valid_reg & ready_in;
    assign sent_inc = sent_reg + CNT_W'(1);

`ifdef STIM_GEN_CORNER_EN
    assign use_lfsr = (mode_reg == MODE_RAND);
`else
    assign use_lfsr = (mode_reg == MODE_RAND) || (mode_reg == MODE_CORNER);
`endif

    stim_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step_en (accept & use_lfsr),
        .state   (lfsr_state)
    );

    // Only the A and B slices of the LFSR feed the outputs.
    assign unused_lfsr_bits = ^{lfsr_state[15:8+DATA_W], lfsr_state[7:DATA_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= MODE_RAND;
            count_reg <= '0;
            sent_reg  <= '0;
            k_reg     <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start_in) begin
                        mode_reg  <= stim_mode_e'(mode_in);
                        count_reg <= count_in;
                        sent_reg  <= '0;
                        k_reg     <= '0;
                        busy_reg  <= 1'b1;
                        if (count_in != '0) begin
                            state_reg <= RUN;
                            valid_reg <= 1'b1;
                        end else begin
                            // Empty burst: go straight to the completion pulse.
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        sent_reg <= sent_inc;
                        k_reg    <= (k_reg == K_MAX) ? '0 : k_reg + K_W'(1);
                        if (sent_inc == count_reg) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Data is a pure function of registered state, so it holds still while
    // a beat is stalled and only moves on acceptance.
    always_comb begin
        a_mux = '0;
        b_mux = '0;
        case (mode_reg)
            MODE_INC: begin
                a_mux = sent_reg[DATA_W-1:0];
                b_mux = ~sent_reg[DATA_W-1:0];
            end
            MODE_WALK: begin
                a_mux = DATA_W'(1) << k_reg;
                b_mux = {a_mux[DATA_W-2:0], a_mux[DATA_W-1]};
            end
`ifdef STIM_GEN_CORNER_EN
            MODE_CORNER: begin
                a_mux = sent_reg[0] ? '1 : '0;
                b_mux = (sent_reg[1] ^ sent_reg[0]) ? '1 : '0;
            end
`endif
            default: begin
                a_mux = lfsr_state[DATA_W-1:0];
                b_mux = lfsr_state[8 +: DATA_W];
            end
        endcase
    end

    assign valid_ou = valid_reg;
    assign a_ou     = valid_reg ? a_mux : '0;
    assign b_ou     = valid_reg ? b_mux : '0;
    assign busy_ou  = busy_reg;
    assign done_ou  = done_reg;
    assign sent_ou  = sent_reg;

endmodule
